// File: rtl/tt_um_mathai_pkg.sv
// Shared constants for the SPI-controlled PWM output block.
package tt_um_mathai_pkg;

  // Register map
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam logic [6:0] MAX_ADDR       = 7'h04;

  // SPI frame: {rw, addr[6:0], data[7:0]}
  localparam int unsigned FRAME_LEN = 16;

  // 3 kHz PWM at a 10 MHz clock
  localparam int unsigned PWM_PERIOD_DEFAULT = 3333;

endpackage

// File: rtl/tt_um_mathai_spi_peripheral.sv
// Write-only SPI mode-0 slave: synchronizers, 16-bit deserializer and register file.
module spi_peripheral
  import tt_um_mathai_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,  // active-high synchronous reset
  input  logic        sclk,
  input  logic        copi,
  input  logic        ncs,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty
);

  logic [1:0]  sclk_sync;
  logic [1:0]  copi_sync;
  logic [1:0]  ncs_sync;
  logic        sclk_prev;
  logic        ncs_prev;
  logic [1:0]  warm;
  logic        idle_seen;
  logic        armed;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        commit;
  logic [6:0]  commit_addr;
  logic [7:0]  commit_data;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise, frame_ok;

  assign sclk_s    = sclk_sync[1];
  assign copi_s    = copi_sync[1];
  assign ncs_s     = ncs_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;

  // Frame is only accepted if its select-low edge was genuinely seen after reset
  assign frame_ok = armed && (bit_cnt == 5'(FRAME_LEN)) && shift_reg[15] &&
                    (shift_reg[14:8] <= MAX_ADDR);

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sclk_sync <= 2'b00;
      copi_sync <= 2'b00;
      ncs_sync  <= 2'b11;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      copi_sync <= {copi_sync[0], copi};
      ncs_sync  <= {ncs_sync[0], ncs};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
    end
  end

  // Deserializer: clear on select fall, shift on SCLK rise, qualify on select rise
  always_ff @(posedge clk) begin
    if (rst_n) begin
      warm        <= 2'd0;
      idle_seen   <= 1'b0;
      armed       <= 1'b0;
      bit_cnt     <= 5'd0;
      shift_reg   <= 16'h0000;
      commit      <= 1'b0;
      commit_addr <= 7'h00;
      commit_data <= 8'h00;
    end else begin
      commit <= 1'b0;
      // The synchronizer holds its reset value for two cycles; ignore edges until it is refilled
      if (warm != 2'd2) warm <= warm + 2'd1;
      if (warm == 2'd2 && ncs_s) idle_seen <= 1'b1;

      if (ncs_fall) begin
        bit_cnt   <= 5'd0;
        shift_reg <= 16'h0000;
        armed     <= idle_seen;
      end else if (ncs_rise) begin
        armed       <= 1'b0;
        commit      <= frame_ok;
        commit_addr <= shift_reg[14:8];
        commit_data <= shift_reg[7:0];
      end else if (sclk_rise && !ncs_s) begin
        shift_reg <= {shift_reg[14:0], copi_s};
        // Saturate so long frames can never wrap back to a valid length
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // Register file, written one cycle after an accepted frame ends
  always_ff @(posedge clk) begin
    if (rst_n) begin
      en_out <= 16'h0000;
      en_pwm <= 16'h0000;
      duty   <= 8'h00;
    end else if (commit) begin
      case (commit_addr)
        ADDR_EN_OUT_LO: en_out[7:0]  <= commit_data;
        ADDR_EN_OUT_HI: en_out[15:8] <= commit_data;
        ADDR_EN_PWM_LO: en_pwm[7:0]  <= commit_data;
        ADDR_EN_PWM_HI: en_pwm[15:8] <= commit_data;
        ADDR_DUTY:      duty         <= commit_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_mathai.sv
// Top level: SPI register file, free-running PWM counter and registered output mux.
module tt_um_mathai
  import tt_um_mathai_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,   // active-high synchronous reset
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned ProdW = (8 + CntW > 20) ? 8 + CntW : 20;

  logic [15:0]     en_out;
  logic [15:0]     en_pwm;
  logic [7:0]      duty;
  logic [CntW-1:0] counter;
  logic [ProdW-1:0] product;
  logic [ProdW-1:0] threshold;
  logic            pwm;
  logic [15:0]     chan;
  logic [15:0]     chan_q;

  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in, ui_in[7:3]};

  spi_peripheral u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (ui_in[0]),
    .copi   (ui_in[1]),
    .ncs    (ui_in[2]),
    .en_out (en_out),
    .en_pwm (en_pwm),
    .duty   (duty)
  );

  // Free-running PWM counter 0..PWM_PERIOD-1
  always_ff @(posedge clk) begin
    if (rst_n) begin
      counter <= '0;
    end else if (counter == CntW'(PWM_PERIOD - 1)) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  // Threshold is recomputed combinationally so a duty write applies immediately
  always_comb begin
    product   = ProdW'(duty) * ProdW'(PWM_PERIOD);
    threshold = product >> 8;
    pwm       = (duty == 8'hFF) || (ProdW'(counter) < threshold);
    chan      = en_out & (~en_pwm | {16{pwm}});
  end

  // Registered channel outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      chan_q <= 16'h0000;
    end else begin
      chan_q <= chan;
    end
  end

  assign uo_out  = chan_q[7:0];
  assign uio_out = chan_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_mathai.sv
// Directed self-checking bench for tt_um_mathai.
module tb_tt_um_mathai;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'b0000_0100;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  tt_um_mathai dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #50 clk = ~clk;  // 10 MHz

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] word, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      ui_in[1] = word[15 - i];
      wait_clk(4);
      ui_in[0] = 1'b1;
      wait_clk(4);
      ui_in[0] = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [15:0] word, input int nbits);
    ui_in[2] = 1'b0;
    wait_clk(4);
    send_bits(word, 0, nbits);
    wait_clk(4);
    ui_in[2] = 1'b1;
    wait_clk(12);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    spi_xfer({1'b1, addr, data}, 16);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (uo_out[0]) ones++;
    end
  endtask

  task automatic measure_pwm(output int period, output int high);
    logic prev, cur;
    int rise1, rise2, fall;
    rise1 = -1; rise2 = -1; fall = -1;
    @(negedge clk);
    prev = uo_out[0];
    for (int t = 0; t < 10000 && rise2 < 0; t++) begin
      @(negedge clk);
      cur = uo_out[0];
      if (cur && !prev) begin
        if (rise1 < 0) rise1 = t;
        else rise2 = t;
      end else if (!cur && prev && rise1 >= 0 && fall < 0) begin
        fall = t;
      end
      prev = cur;
    end
    period = (rise2 >= 0) ? rise2 - rise1 : -1;
    high   = (fall >= 0) ? fall - rise1 : -1;
  endtask

  initial begin
    int per, hi, ones;

    // Reset for 5 clocks
    wait_clk(5);
    @(negedge clk);
    check_eq("rst_uo_during", uo_out, 8'h00);
    rst_n = 1'b0;
    wait_clk(2);
    @(negedge clk);
    check_eq("rst_uo", uo_out, 8'h00);
    check_eq("rst_uio", uio_out, 8'h00);
    check_eq("rst_oe", uio_oe, 8'hFF);
    wait_clk(5);

    // Static outputs
    spi_write(7'h00, 8'hF0);
    spi_write(7'h01, 8'hCC);
    @(negedge clk);
    check_eq("static_uo", uo_out, 8'hF0);
    check_eq("static_uio", uio_out, 8'hCC);
    wait_clk(1000);
    @(negedge clk);
    check_eq("static_uo_hold", uo_out, 8'hF0);
    check_eq("static_uio_hold", uio_out, 8'hCC);

    // PWM 50%: 128*3333>>8 = 1666 high of 3333
    spi_write(7'h00, 8'h01);
    spi_write(7'h01, 8'h00);
    spi_write(7'h02, 8'h01);
    spi_write(7'h04, 8'h80);
    measure_pwm(per, hi);
    check_eq("pwm50_period", per, 3333);
    check_eq("pwm50_high", hi, 1666);
    check_eq("pwm50_upper", uo_out[7:1], 7'h00);

    // Duty 0 -> always low
    spi_write(7'h04, 8'h00);
    wait_clk(10);
    count_ones(3400, ones);
    check_eq("duty00_ones", ones, 0);

    // Duty FF -> always high
    spi_write(7'h04, 8'hFF);
    wait_clk(10);
    count_ones(3400, ones);
    check_eq("dutyFF_ones", ones, 3400);

    // en_out[0]=0 with en_pwm[0]=1 -> low
    spi_write(7'h04, 8'h80);
    spi_write(7'h00, 8'h00);
    wait_clk(10);
    count_ones(3400, ones);
    check_eq("pwm_disabled_ones", ones, 0);

    // Invalid frames leave registers unchanged
    spi_write(7'h02, 8'h00);
    spi_write(7'h00, 8'h3C);
    @(negedge clk);
    check_eq("inv_base_uo", uo_out, 8'h3C);
    spi_xfer(16'h00FF, 16);          // read to 0x00
    @(negedge clk);
    check_eq("inv_read_uo", uo_out, 8'h3C);
    spi_xfer(16'h85FF, 16);          // write to 0x05
    @(negedge clk);
    check_eq("inv_addr5_uo", uo_out, 8'h3C);
    check_eq("inv_addr5_uio", uio_out, 8'h00);
    spi_xfer(16'h88FF, 16);          // write to 0x08
    @(negedge clk);
    check_eq("inv_addr8_uo", uo_out, 8'h3C);
    spi_xfer(16'h80FF, 15);          // short frame
    @(negedge clk);
    check_eq("inv_short_uo", uo_out, 8'h3C);
    spi_xfer(16'h80FF, 17);          // long frame
    @(negedge clk);
    check_eq("inv_long_uo", uo_out, 8'h3C);

    // Reset mid-frame aborts the frame
    ui_in[2] = 1'b0;
    wait_clk(4);
    send_bits(16'h80FF, 0, 8);
    rst_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b0;
    send_bits(16'h80FF, 8, 8);
    wait_clk(4);
    ui_in[2] = 1'b1;
    wait_clk(12);
    @(negedge clk);
    check_eq("midrst_uo", uo_out, 8'h00);
    check_eq("midrst_uio", uio_out, 8'h00);

    // Valid write after recovery
    spi_write(7'h00, 8'h5A);
    @(negedge clk);
    check_eq("post_rst_uo", uo_out, 8'h5A);
    check_eq("post_rst_oe", uio_oe, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
